// File: rtl/rifl_axis_sync_fifo.sv
// Single-clock AXI-Stream FIFO, first-word-fall-through, with occupancy and almost flags.
// Define RIFL_AXIS_FIFO_PKT_MODE_EN to hold the output until a whole packet is buffered.
module rifl_axis_sync_fifo #(
    parameter int unsigned DWIDTH        = 32,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned AFULL_THRESH  = DEPTH - 2,
    parameter int unsigned AEMPTY_THRESH = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DWIDTH-1:0]        s_axis_tdata,
    input  logic                     s_axis_tlast,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    output logic [DWIDTH-1:0]        m_axis_tdata,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic                     almost_full,
    output logic                     almost_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    // Reject illegal configurations at elaboration time
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("rifl_axis_sync_fifo: DEPTH must be a power of two >= 2");
    end
    if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_bad_afull
        $error("rifl_axis_sync_fifo: AFULL_THRESH must be in 1..DEPTH");
    end
    if (AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
        $error("rifl_axis_sync_fifo: AEMPTY_THRESH must be in 0..DEPTH-1");
    end

    logic [DWIDTH:0] mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr_nxt;
    logic [PW-1:0]   rd_ptr_nxt;
    logic [PW-1:0]   cnt_nxt;
    logic            rdy_en;
    logic            empty;
    logic            full;
    logic            wr_fire;
    logic            rd_fire;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    assign s_axis_tready = rdy_en & ~full;
    assign wr_fire       = s_axis_tvalid & s_axis_tready;
    assign rd_fire       = m_axis_tvalid & m_axis_tready;

`ifdef RIFL_AXIS_FIFO_PKT_MODE_EN
    logic [PW-1:0] pkt_cnt;
    logic          pkt_inc;
    logic          pkt_dec;

    assign pkt_inc = wr_fire & s_axis_tlast;
    assign pkt_dec = rd_fire & m_axis_tlast;

    // Complete packets held; the full escape lets oversize packets drain cut-through
    assign m_axis_tvalid = ~empty & ((pkt_cnt != '0) | full);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt <= '0;
        end else begin
            case ({pkt_inc, pkt_dec})
                2'b10:   pkt_cnt <= pkt_cnt + PW'(1);
                2'b01:   pkt_cnt <= pkt_cnt - PW'(1);
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end
`else
    assign m_axis_tvalid = ~empty;
`endif

    // Head entry falls through combinationally; only a read moves rd_ptr
    assign {m_axis_tlast, m_axis_tdata} = mem[rd_ptr[AW-1:0]];

    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (wr_fire) begin
            wr_ptr_nxt = wr_ptr + PW'(1);
        end
        if (rd_fire) begin
            rd_ptr_nxt = rd_ptr + PW'(1);
        end
        cnt_nxt = wr_ptr_nxt - rd_ptr_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rdy_en       <= 1'b0;
            fifo_cnt     <= '0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            rdy_en       <= 1'b1;
            fifo_cnt     <= cnt_nxt;
            almost_full  <= (cnt_nxt >= PW'(AFULL_THRESH));
            almost_empty <= (cnt_nxt <= PW'(AEMPTY_THRESH));
        end
    end

    // Storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
        end
    end

endmodule

// File: tb/tb_rifl_axis_sync_fifo.sv
// Self-checking bench for rifl_axis_sync_fifo: queue-based reference model plus directed literals.
module tb_rifl_axis_sync_fifo;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam int unsigned AF    = DEPTH - 2;
    localparam int unsigned AE    = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tlast = 1'b0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tlast;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic [CW-1:0] fifo_cnt;
    logic          almost_full;
    logic          almost_empty;

    rifl_axis_sync_fifo #(
        .DWIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .fifo_cnt(fifo_cnt), .almost_full(almost_full), .almost_empty(almost_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    beat_t         q[$];
    bit            rdy_m = 1'b0;
    bit            en_chk = 1'b0;
    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] seq = '0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic bit exp_ready();
        return rdy_m && (q.size() < DEPTH);
    endfunction

    function automatic bit exp_valid();
        bit has_pkt = 1'b0;
        foreach (q[i]) if (q[i].last) has_pkt = 1'b1;
`ifdef RIFL_AXIS_FIFO_PKT_MODE_EN
        return (q.size() > 0) && (has_pkt || (q.size() == DEPTH));
`else
        return (q.size() > 0) && (has_pkt || 1'b1);
`endif
    endfunction

    // Reference model advance at a clock edge, using inputs held from before the edge
    task automatic model_update();
        bit wf;
        bit rf;
        if (!rst_n) begin
            q.delete();
            rdy_m = 1'b0;
            return;
        end
        wf = s_tvalid && exp_ready();
        rf = exp_valid() && m_tready;
        if (rf) void'(q.pop_front());
        if (wf) begin
            q.push_back('{last: s_tlast, data: s_tdata});
            seq = seq + 1;
        end
        rdy_m = 1'b1;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #2;
    endtask

    task automatic fill_to(input int n, input logic last);
        for (int k = 0; k < 400 && q.size() < n; k++) begin
            s_tvalid = 1'b1;
            s_tdata  = seq;
            s_tlast  = last;
            cycle();
        end
        s_tvalid = 1'b0;
        if (q.size() < n) chk("fill_timeout", 64'(q.size()), 64'(n));
    endtask

    task automatic drain();
        m_tready = 1'b1;
        for (int k = 0; k < 400 && q.size() > 0; k++) cycle();
        m_tready = 1'b0;
        if (q.size() > 0) chk("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    // Compare every cycle against the model, away from the active edge
    always @(negedge clk) begin
        if (en_chk) begin
            chk("s_tready", 64'(s_tready), 64'(exp_ready()));
            chk("m_tvalid", 64'(m_tvalid), 64'(exp_valid()));
            if (exp_valid() && m_tvalid) begin
                chk("m_tdata", 64'(m_tdata), 64'(q[0].data));
                chk("m_tlast", 64'(m_tlast), 64'(q[0].last));
            end
            chk("fifo_cnt", 64'(fifo_cnt), 64'(q.size()));
            chk("almost_full", 64'(almost_full), 64'(q.size() >= AF));
            chk("almost_empty", 64'(almost_empty), 64'(q.size() <= AE));
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            en_chk = 1'b1;
        end
        chk("rst_cnt", 64'(fifo_cnt), 64'd0);
        chk("rst_tready", 64'(s_tready), 64'd0);
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_aempty", 64'(almost_empty), 64'd1);
        rst_n = 1'b1;
        #1 chk("rel_tready_low", 64'(s_tready), 64'd0);
        cycle();
        chk("rel_tready_high", 64'(s_tready), 64'd1);

        // Fill with 0x00..0x0F, then drain in order
        fill_to(13, 1'b0);
        chk("af_at13", 64'(almost_full), 64'd0);
        fill_to(14, 1'b0);
        chk("af_at14", 64'(almost_full), 64'd1);
        fill_to(15, 1'b0);
        fill_to(16, 1'b1);
        chk("full_cnt", 64'(fifo_cnt), 64'd16);
        chk("full_tready", 64'(s_tready), 64'd0);
        for (int k = 0; k < 16; k++) begin
            chk("drain_order", 64'(m_tdata), 64'(k));
            chk("drain_valid", 64'(m_tvalid), 64'd1);
            m_tready = 1'b1;
            cycle();
        end
        m_tready = 1'b0;
        chk("drained_valid", 64'(m_tvalid), 64'd0);
        chk("drained_cnt", 64'(fifo_cnt), 64'd0);

        // Simultaneous read/write at count 8
        fill_to(8, 1'b1);
        s_tvalid = 1'b1;
        s_tlast  = 1'b1;
        m_tready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            s_tdata = seq;
            cycle();
            chk("simul_cnt", 64'(fifo_cnt), 64'd8);
        end
        s_tvalid = 1'b0;
        m_tready = 1'b0;

        // Full plus a one-cycle read
        fill_to(16, 1'b1);
        s_tvalid = 1'b1;
        s_tdata  = seq;
        m_tready = 1'b1;
        cycle();
        m_tready = 1'b0;
        chk("fr_cnt_after_read", 64'(fifo_cnt), 64'd15);
        chk("fr_tready_back", 64'(s_tready), 64'd1);
        s_tdata = seq;
        cycle();
        chk("fr_cnt_refill", 64'(fifo_cnt), 64'd16);
        s_tvalid = 1'b0;
        drain();

`ifdef RIFL_AXIS_FIFO_PKT_MODE_EN
        for (int b = 0; b < 4; b++) begin
            s_tvalid = 1'b1;
            s_tdata  = seq;
            s_tlast  = (b == 3);
            cycle();
            chk("pkt4_valid", 64'(m_tvalid), 64'(b == 3));
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            chk("pkt4_read_valid", 64'(m_tvalid), 64'd1);
            cycle();
        end
        m_tready = 1'b0;
        chk("pkt4_done", 64'(m_tvalid), 64'd0);
        for (int b = 0; b < 20; b++) begin
            s_tvalid = 1'b1;
            s_tdata  = seq;
            s_tlast  = 1'b0;
            cycle();
            chk("long_valid", 64'(m_tvalid), 64'(b >= 15));
        end
        s_tlast  = 1'b1;
        m_tready = 1'b1;
        for (int b = 0; b < 30; b++) begin
            s_tdata = seq;
            cycle();
        end
        s_tvalid = 1'b0;
        drain();
`endif

        // Randomized traffic with varying pressure
        for (int seg = 0; seg < 6; seg++) begin
            int wp = $urandom_range(1, 9);
            int rp = $urandom_range(1, 9);
            for (int k = 0; k < 500; k++) begin
                s_tvalid = ($urandom_range(0, 9) < wp);
                s_tdata  = DW'($urandom);
                s_tlast  = ($urandom_range(0, 3) == 0);
                m_tready = ($urandom_range(0, 9) < rp);
                cycle();
            end
        end
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        s_tlast  = 1'b1;
        drain();

        // Asynchronous reset in the middle of a cycle at count 5
        fill_to(5, 1'b1);
        chk("mid_pre_cnt", 64'(fifo_cnt), 64'd5);
        rst_n = 1'b0;
        q.delete();
        rdy_m = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(m_tvalid), 64'd0);
        chk("mid_rst_cnt", 64'(fifo_cnt), 64'd0);
        chk("mid_rst_aempty", 64'(almost_empty), 64'd1);
        chk("mid_rst_tready", 64'(s_tready), 64'd0);
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("mid_rel_tready", 64'(s_tready), 64'd1);
        for (int k = 0; k < 200; k++) begin
            s_tvalid = $urandom_range(0, 1);
            s_tdata  = DW'($urandom);
            s_tlast  = ($urandom_range(0, 2) == 0);
            m_tready = $urandom_range(0, 1);
            cycle();
        end
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        @(negedge clk);
        #1;
        en_chk = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
